// File: rtl/writeback_queue.sv
// writeback_queue
//   Small in-order queue of pending register-file writes. A producer offers
//   (address, data) pairs. The queue drains them, oldest first, into the
//   register-file write port whenever that port is free. While entries are
//   pending, two read ports can look up the youngest queued value for a
//   register, so a reader never sees stale register-file contents.
//
// Ports
//   Clock, Reset          single clock; synchronous active-high reset
//   InValid/InAddr/InData producer offer; taken when InValid & InReady
//   InReady               queue not full
//   PortFree              register-file write port available this cycle
//   RegWrite/WriteAddr/   head-entry write to the register file; a pop
//   WriteData             happens on every edge where RegWrite is high
//   ReadAddrN/HitN/       bypass lookup returning the youngest pending
//   HitDataN              entry that matches ReadAddrN (N = 1, 2)
//   Count                 number of pending entries, 0..DEPTH

module writeback_queue #(
    parameter int DEPTH = 4  // power of two, 2..16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InValid,
    input  logic [4:0]  InAddr,
    input  logic [31:0] InData,
    output logic        InReady,
    input  logic        PortFree,
    output logic        RegWrite,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData,
    input  logic [4:0]  ReadAddr1,
    input  logic [4:0]  ReadAddr2,
    output logic        Hit1,
    output logic [31:0] HitData1,
    output logic        Hit2,
    output logic [31:0] HitData2,
    output logic [4:0]  Count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [4:0]    count;

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic          empty;
    logic          full;
    logic          accept;
    logic          enq;
    logic          pop;

    assign empty   = (count == 5'd0);
    assign full    = (count == 5'(DEPTH));

    // Full means not ready even if the head drains this same cycle. This keeps
    // InReady free of any combinational dependence on PortFree.
    assign InReady = ~full;

    // Writes to register 0 are handshaken but dropped, because that register
    // is hardwired to zero and must never be written or bypassed.
    assign accept  = InValid & InReady & ~Reset;
    assign enq     = accept & (InAddr != 5'd0);

    assign RegWrite  = ~empty & PortFree & ~Reset;
    assign pop       = RegWrite;

    assign WriteAddr = empty ? 5'd0  : addr_q[head];
    assign WriteData = empty ? 32'd0 : data_q[head];
    assign Count     = count;

    // Pointer and occupancy state. The pointers are exactly log2(DEPTH) bits,
    // so they wrap from DEPTH-1 to 0 by natural overflow.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= 5'd0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            case ({enq, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset. Slots outside the head..count window are
    // never observed.
    always_ff @(posedge Clock) begin
        if (enq) begin
            addr_q[tail] <= InAddr;
            data_q[tail] <= InData;
        end
    end

    // Bypass lookup. Walk the pending window from oldest to youngest, so the
    // last match wins. The head entry takes part even while it is being
    // written this cycle. The offer on InData is not included.
    function automatic logic [32:0] lookup(input logic [4:0] ra);
        logic          hit;
        logic [31:0]   data;
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((5'(i) < count) && (ra != 5'd0) && (addr_q[idx] == ra)) begin
                hit  = 1'b1;
                data = data_q[idx];
            end
        end
        return {hit, data};
    endfunction

    always_comb begin
        {Hit1, HitData1} = lookup(ReadAddr1);
        {Hit2, HitData2} = lookup(ReadAddr2);
    end

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue
//   Self-checking bench for writeback_queue (DEPTH = 4). A reference model
//   keeps pending writes in a queue. Directed scenarios check fixed expected
//   values, and a randomized run compares every output to the model on
//   every cycle.

module tb_writeback_queue;

    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        Reset, InValid, PortFree;
    logic [4:0]  InAddr, ReadAddr1, ReadAddr2;
    logic [31:0] InData;
    logic        InReady, RegWrite, Hit1, Hit2;
    logic [4:0]  WriteAddr, Count;
    logic [31:0] WriteData, HitData1, HitData2;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset),
        .InValid(InValid), .InAddr(InAddr), .InData(InData), .InReady(InReady),
        .PortFree(PortFree), .RegWrite(RegWrite),
        .WriteAddr(WriteAddr), .WriteData(WriteData),
        .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
        .Hit1(Hit1), .HitData1(HitData1), .Hit2(Hit2), .HitData2(HitData2),
        .Count(Count)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   errs   = 0;
    int   checks = 0;

    // Advance one clock and apply the queue rules to the model, using the
    // inputs present at the edge. Returns 2 units after the edge.
    task automatic tick();
        bit rdy;
        @(posedge Clock);
        if (Reset) begin
            mq.delete();
        end else begin
            rdy = (mq.size() != DEPTH);
            if (mq.size() != 0 && PortFree) void'(mq.pop_front());
            if (InValid && rdy && InAddr != 5'd0) mq.push_back('{a: InAddr, d: InData});
        end
        #2;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic pf);
        InValid = v; InAddr = a; InData = d; PortFree = pf;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        ReadAddr1 = 5'd0; ReadAddr2 = 5'd0;
        tick(); tick();
        Reset = 1'b0;
        ReadAddr1 = 5'd3; ReadAddr2 = 5'd5;
        #1;
        checks++;
        if ({InReady, RegWrite, WriteAddr, WriteData, Count} !== {1'b1, 1'b0, 5'd0, 32'd0, 5'd0}) begin
            errs++;
            $display("FAIL reset_state: rdy=%b rw=%b wa=%0d wd=%h cnt=%0d want 1 0 0 0 0",
                     InReady, RegWrite, WriteAddr, WriteData, Count);
        end
        checks++;
        if ({Hit1, HitData1, Hit2, HitData2} !== {1'b0, 32'd0, 1'b0, 32'd0}) begin
            errs++;
            $display("FAIL reset_hits: h1=%b d1=%h h2=%b d2=%h want all 0", Hit1, HitData1, Hit2, HitData2);
        end
    endtask

    task automatic test_bypass();
        ReadAddr1 = 5'd3; ReadAddr2 = 5'd5;
        drive(1'b1, 5'd3, 32'hA, 1'b0); tick();
        drive(1'b1, 5'd5, 32'hB, 1'b0); tick();
        drive(1'b1, 5'd3, 32'hC, 1'b0);
        // The offer being accepted this cycle must not be visible yet.
        checks++;
        if ({Hit1, HitData1} !== {1'b1, 32'hA}) begin
            errs++;
            $display("FAIL no_offer_bypass: hit=%b data=%h want 1 0000000a", Hit1, HitData1);
        end
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        checks++;
        if ({Count, RegWrite} !== {5'd3, 1'b0}) begin
            errs++;
            $display("FAIL bypass_count: cnt=%0d rw=%b want 3 0", Count, RegWrite);
        end
        checks++;
        if ({Hit1, HitData1, Hit2, HitData2} !== {1'b1, 32'hC, 1'b1, 32'hB}) begin
            errs++;
            $display("FAIL bypass_youngest: h1=%b d1=%h h2=%b d2=%h want 1 c 1 b",
                     Hit1, HitData1, Hit2, HitData2);
        end
    endtask

    task automatic test_drain();
        logic [4:0]  ea [3] = '{5'd3, 5'd5, 5'd3};
        logic [31:0] ed [3] = '{32'hA, 32'hB, 32'hC};
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1);
            checks++;
            if ({RegWrite, WriteAddr, WriteData} !== {1'b1, ea[k], ed[k]}) begin
                errs++;
                $display("FAIL drain_%0d: rw=%b wa=%0d wd=%h want 1 %0d %h",
                         k, RegWrite, WriteAddr, WriteData, ea[k], ed[k]);
            end
            tick();
        end
        checks++;
        if ({Count, RegWrite, Hit1, Hit2} !== {5'd0, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL drain_empty: cnt=%0d rw=%b h1=%b h2=%b want 0 0 0 0", Count, RegWrite, Hit1, Hit2);
        end
    endtask

    // Pointers currently sit at 3, so filling four entries wraps them.
    task automatic test_full_wrap();
        logic [4:0] order [4] = '{5'd2, 5'd3, 5'd4, 5'd6};
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 5'(k), 32'h100 + k, 1'b0); tick();
        end
        drive(1'b1, 5'd6, 32'h105, 1'b0);
        checks++;
        if ({InReady, Count} !== {1'b0, 5'd4}) begin
            errs++;
            $display("FAIL full: rdy=%b cnt=%0d want 0 4", InReady, Count);
        end
        tick();
        drive(1'b1, 5'd6, 32'h105, 1'b1);
        checks++;
        if ({InReady, RegWrite, WriteAddr, Count} !== {1'b0, 1'b1, 5'd1, 5'd4}) begin
            errs++;
            $display("FAIL full_drain: rdy=%b rw=%b wa=%0d cnt=%0d want 0 1 1 4", InReady, RegWrite, WriteAddr, Count);
        end
        tick();
        drive(1'b1, 5'd6, 32'h105, 1'b0);
        checks++;
        if ({InReady, Count} !== {1'b1, 5'd3}) begin
            errs++;
            $display("FAIL after_pop: rdy=%b cnt=%0d want 1 3", InReady, Count);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1);
            checks++;
            if ({RegWrite, WriteAddr, WriteData} !== {1'b1, order[k], 32'h100 + 32'(order[k] == 5'd6 ? 5 : order[k])}) begin
                errs++;
                $display("FAIL wrap_order_%0d: rw=%b wa=%0d wd=%h want addr %0d", k, RegWrite, WriteAddr, WriteData, order[k]);
            end
            tick();
        end
    endtask

    task automatic test_zero_addr();
        ReadAddr1 = 5'd0;
        drive(1'b1, 5'd0, 32'hFFFF, 1'b1);
        checks++;
        if (InReady !== 1'b1) begin
            errs++;
            $display("FAIL zero_ready: rdy=%b want 1", InReady);
        end
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        checks++;
        if ({Count, RegWrite, Hit1, HitData1} !== {5'd0, 1'b0, 1'b0, 32'd0}) begin
            errs++;
            $display("FAIL zero_dropped: cnt=%0d rw=%b h1=%b d1=%h want 0 0 0 0", Count, RegWrite, Hit1, HitData1);
        end
    endtask

    task automatic test_push_pop();
        drive(1'b1, 5'd8, 32'h11, 1'b0); tick();
        drive(1'b1, 5'd9, 32'h22, 1'b0); tick();
        drive(1'b1, 5'd7, 32'h1, 1'b1);
        checks++;
        if ({InReady, RegWrite, Count} !== {1'b1, 1'b1, 5'd2}) begin
            errs++;
            $display("FAIL pp_before: rdy=%b rw=%b cnt=%0d want 1 1 2", InReady, RegWrite, Count);
        end
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        checks++;
        if ({Count, WriteAddr, WriteData} !== {5'd2, 5'd9, 32'h22}) begin
            errs++;
            $display("FAIL pp_after: cnt=%0d wa=%0d wd=%h want 2 9 22", Count, WriteAddr, WriteData);
        end
        tick();
        checks++;
        if ({WriteAddr, WriteData} !== {5'd7, 32'h1}) begin
            errs++;
            $display("FAIL pp_last: wa=%0d wd=%h want 7 1", WriteAddr, WriteData);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'(10 + k), 32'h300 + k, 1'b0); tick();
        end
        Reset = 1'b1;
        drive(1'b1, 5'd15, 32'h999, 1'b1);
        checks++;
        if ({RegWrite, Count} !== {1'b0, 5'd3}) begin
            errs++;
            $display("FAIL rst_no_write: rw=%b cnt=%0d want 0 3", RegWrite, Count);
        end
        tick();
        Reset = 1'b0;
        ReadAddr1 = 5'd10; ReadAddr2 = 5'd15;
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        checks++;
        if ({Count, InReady, Hit1, HitData1, Hit2, HitData2} !== {5'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0}) begin
            errs++;
            $display("FAIL rst_cleared: cnt=%0d rdy=%b h1=%b d1=%h h2=%b d2=%h want 0 1 0 0 0 0",
                     Count, InReady, Hit1, HitData1, Hit2, HitData2);
        end
    endtask

    task automatic test_random();
        logic        e_rw, e_h1, e_h2;
        logic [4:0]  e_wa;
        logic [31:0] e_wd, e_d1, e_d2;
        int          bad = 0;
        for (int n = 0; n < 3000; n++) begin
            Reset     = ($urandom_range(0, 59) == 0);
            ReadAddr1 = 5'($urandom_range(0, 7));
            ReadAddr2 = 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 2) == 0));
            e_rw = (mq.size() != 0) && PortFree && !Reset;
            e_wa = (mq.size() != 0) ? mq[0].a : 5'd0;
            e_wd = (mq.size() != 0) ? mq[0].d : 32'd0;
            e_h1 = 1'b0; e_d1 = 32'd0; e_h2 = 1'b0; e_d2 = 32'd0;
            for (int k = 0; k < mq.size(); k++) begin
                if (ReadAddr1 != 0 && mq[k].a == ReadAddr1) begin e_h1 = 1'b1; e_d1 = mq[k].d; end
                if (ReadAddr2 != 0 && mq[k].a == ReadAddr2) begin e_h2 = 1'b1; e_d2 = mq[k].d; end
            end
            checks++;
            if ({InReady, Count, RegWrite, WriteAddr, WriteData} !==
                {1'(mq.size() != DEPTH), 5'(mq.size()), e_rw, e_wa, e_wd}) begin
                errs++;
                if (bad++ < 10)
                    $display("FAIL rand_write[%0d]: rdy=%b cnt=%0d rw=%b wa=%0d wd=%h want rdy=%b cnt=%0d rw=%b wa=%0d wd=%h",
                             n, InReady, Count, RegWrite, WriteAddr, WriteData,
                             mq.size() != DEPTH, mq.size(), e_rw, e_wa, e_wd);
            end
            checks++;
            if ({Hit1, HitData1, Hit2, HitData2} !== {e_h1, e_d1, e_h2, e_d2}) begin
                errs++;
                if (bad++ < 10)
                    $display("FAIL rand_hit[%0d]: h1=%b d1=%h h2=%b d2=%h want %b %h %b %h",
                             n, Hit1, HitData1, Hit2, HitData2, e_h1, e_d1, e_h2, e_d2);
            end
            tick();
        end
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; InValid = 1'b0; InAddr = '0; InData = '0; PortFree = 1'b0;
        ReadAddr1 = '0; ReadAddr2 = '0;
        test_reset();
        test_bypass();
        test_drain();
        test_full_wrap();
        test_zero_addr();
        test_push_pop();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 SHALL have port Clock  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port InValid  input  1  producer offers a register write this cycle.
REQ-005 SHALL have port InAddr  input  5  destination register of offered write.
REQ-006 SHALL have port InData  input  32  data of offered write.
REQ-007 SHALL have port InReady  output  1  queue can accept; equals not-full.
REQ-008 SHALL have port PortFree  input  1  register-file write port available this cycle.
REQ-009 SHALL have port RegWrite  output  1  write strobe to register file.
REQ-010 SHALL have port WriteAddr  output  5  register-file write address (head entry).
REQ-011 SHALL have port WriteData  output  32  register-file write data (head entry).
REQ-012 SHALL have port ReadAddr1  input  5  lookup address for bypass port 1.
REQ-013 SHALL have port ReadAddr2  input  5  lookup address for bypass port 2.
REQ-014 SHALL have port Hit1  output  1  pending entry matches ReadAddr1.
REQ-015 SHALL have port HitData1  output  32  data of youngest matching entry for port 1.
REQ-016 SHALL have port Hit2  output  1  pending entry matches ReadAddr2.
REQ-017 SHALL have port HitData2  output  32  data of youngest matching entry for port 2.
REQ-018 SHALL have port Count  output  5  number of pending entries, 0..DEPTH.

Function
REQ-019 SHALL implement a circular FIFO: head/tail pointers mod DEPTH, plus Count.
REQ-020 SHALL accept an offer when InValid and InReady are both high at a posedge.
REQ-021 SHALL consume but not enqueue an accepted offer with InAddr = 0 (register 0 is hardwired zero).
REQ-022 SHALL hold InReady low while Count = DEPTH, regardless of a simultaneous drain.
REQ-023 SHALL drive RegWrite = (Count != 0) and PortFree, combinationally.
REQ-024 SHALL drive WriteAddr/WriteData from the head entry; value 0 when empty.
REQ-025 SHALL pop the head at a posedge where RegWrite is high.
REQ-026 SHALL allow push and pop in the same cycle when not full; Count then unchanged.
REQ-027 SHALL make an entry accepted at edge N eligible for RegWrite in the cycle after N (latency 1 cycle minimum).
REQ-028 SHALL drain strictly in acceptance order; PortFree low stalls drain with no entry lost.
REQ-029 SHALL assert HitX combinationally when ReadAddrX != 0 and any pending entry, including the head being written this cycle, has matching address.
REQ-030 SHALL drive HitDataX from the youngest matching entry; 0 when HitX low.
REQ-031 SHALL not bypass the offer on InData in its acceptance cycle; it is visible from the next cycle.
REQ-032 SHALL wrap pointers from DEPTH-1 to 0 without gap or duplication.

Reset
REQ-033 SHALL, when Reset is high at a posedge, clear head, tail and Count to 0 and discard pending entries.
REQ-034 SHALL ignore InValid and suppress pop at a posedge where Reset is high.
REQ-035 SHALL after reset present InReady=1, RegWrite=0, WriteAddr=0, WriteData=0, Hit1=Hit2=0, HitData1=HitData2=0, Count=0.
REQ-036 SHALL, with Reset held high, keep RegWrite low even if PortFree is high.

Verification
REQ-037 SHALL cover: PortFree=0, push (3,0xA),(5,0xB),(3,0xC) -> Count=3, Hit1 for ReadAddr1=3 gives 0xC, ReadAddr2=5 gives 0xB.
REQ-038 SHALL cover: then PortFree=1 -> RegWrite on three consecutive cycles with (3,0xA),(5,0xB),(3,0xC); Count returns 0; RegWrite low after.
REQ-039 SHALL cover: PortFree=0, push DEPTH entries -> InReady=0 at Count=4; fifth offer held until one pop, then accepted; order preserved across pointer wrap.
REQ-040 SHALL cover: push (0,0xFFFF) -> InReady=1, Count stays 0, RegWrite never asserted, Hit1=0 for ReadAddr1=0.
REQ-041 SHALL cover: simultaneous push (7,0x1) and pop with Count=2 -> Count stays 2, next drained entry is former second entry.
REQ-042 SHALL cover: Reset high with Count=3 and PortFree=1 -> no RegWrite that cycle; next cycle Count=0, InReady=1, Hit outputs 0.
